gcd_ctrl: RTL and testbench

Sequencing controller for the GCD subtract-and-compare datapath (`gcdpath`). It accepts a start request, loads both operand registers, then steers one subtraction per clock from the datapath's comparator flags until the operands are equal. It then fires `output_en` and reports completion with a one-cycle `done` pulse. It sits between the top-level requester and `gcdpath`, and is the only driver of the datapath's select and load controls.

---
 rtl/gcd_ctrl_if.sv | 35 +++
 rtl/gcd_ctrl.sv | 135 +++++++++++++
 tb/tb_gcd_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gcd_ctrl_if
// Description : Handshake, comparator-flag and datapath-control bundle
//               between the GCD requester/datapath and gcd_ctrl.
// Revision    : 1.0
// ============================================================================
interface gcd_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_sel;
    logic             b_sel;
    logic             a_ld;
    logic             b_ld;
    logic             output_en;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start, a_gt_b, a_eq_b, a_lt_b,
        input  a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err, iter_count
    );

    modport slave (
        input  start, a_gt_b, a_eq_b, a_lt_b,
        output a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err, iter_count
    );
endinterface
`default_nettype wire

// File: rtl/gcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gcd_ctrl
// Description : Sequencer for the GCD subtract-and-compare datapath.
//               Optional watchdog enabled by macro GCD_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module gcd_ctrl #(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
    input  wire logic clk,
    input  wire logic rst,
    gcd_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    if (64'(MAX_ITER) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_max_iter
        $error("MAX_ITER does not fit in iter_count");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_iter;
    logic             r_err;

    logic w_a_sel, w_b_sel, w_a_ld, w_b_ld, w_output_en;
    logic w_busy, w_done, w_err;
    logic w_iter_clr, w_iter_inc, w_err_set;
    logic w_flags_ok, w_timeout;

    assign w_flags_ok = ({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} == 3'b100) ||
                        ({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} == 3'b010) ||
                        ({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} == 3'b001);

`ifdef GCD_TIMEOUT_EN
    assign w_timeout = (r_iter == MAX_ITER[CNT_W-1:0]) && !bus.a_eq_b;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_a_sel     = 1'b0;
        w_b_sel     = 1'b0;
        w_a_ld      = 1'b0;
        w_b_ld      = 1'b0;
        w_output_en = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_iter_clr  = 1'b0;
        w_iter_inc  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_a_sel     = 1'b1;
                w_b_sel     = 1'b1;
                w_a_ld      = 1'b1;
                w_b_ld      = 1'b1;
                w_busy      = 1'b1;
                w_iter_clr  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                // Malformed flags or watchdog expiry abort with no register updates
                if (!w_flags_ok || w_timeout) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (bus.a_eq_b) begin
                    w_output_en = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (bus.a_gt_b) begin
                    w_a_ld     = 1'b1;
                    w_iter_inc = 1'b1;
                end else begin
                    w_b_ld     = 1'b1;
                    w_iter_inc = 1'b1;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_err       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_iter  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_iter_clr) begin
                r_iter <= '0;
            end else if (w_iter_inc && (r_iter != {CNT_W{1'b1}})) begin
                r_iter <= r_iter + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.a_sel      = w_a_sel;
    assign bus.b_sel      = w_b_sel;
    assign bus.a_ld       = w_a_ld;
    assign bus.b_ld       = w_b_ld;
    assign bus.output_en  = w_output_en;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = w_err;
    assign bus.iter_count = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_gcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_ctrl
// Description : Bench for gcd_ctrl with a behavioural gcdpath and a
//               cycle-level reference model. Honours GCD_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module tb_gcd_ctrl;

`ifdef GCD_TIMEOUT_EN
    localparam int MAXIT = 10;
    localparam int RMAX  = 10;
`else
    localparam int MAXIT = 65535;
    localparam int RMAX  = 200;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_r;
    logic [15:0] in1, in2;
    logic [15:0] ra, rb, rout;
    logic        force_en;
    logic [2:0]  force_v;
    logic        chk_en;

    int checks   = 0;
    int failures = 0;

    gcd_ctrl_if #(.CNT_W(16)) bus ();

    gcd_ctrl #(
        .CNT_W    (16),
        .MAX_ITER (MAXIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.start  = start_r;
    assign bus.a_gt_b = force_en ? force_v[2] : (ra > rb);
    assign bus.a_eq_b = force_en ? force_v[1] : (ra == rb);
    assign bus.a_lt_b = force_en ? force_v[0] : (ra < rb);

    // Behavioural gcdpath
    always @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rout <= '0;
        end else begin
            if (bus.a_ld) ra <= bus.a_sel ? in1 : (ra - rb);
            if (bus.b_ld) rb <= bus.b_sel ? in2 : (rb - ra);
            if (bus.output_en) rout <= ra;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Subtraction count via quotient steps of Euclid's algorithm
    function automatic int sub_steps(input int a, input int b);
        int n = 0;
        while (a != b) begin
            if (a > b) begin
                int k = (a - 1) / b;
                n += k;
                a -= k * b;
            end else begin
                int k = (b - 1) / a;
                n += k;
                b -= k * a;
            end
        end
        return n;
    endfunction

    function automatic int gcd_of(input int a, input int b);
        while (b != 0) begin
            int t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Reference model: phase = cycles since the start edge (0 = idle)
    int phase = 0, n = 0, ma = 0, mb = 0, g = 0, m_iter = 0;

    always @(negedge clk) begin
        logic e_asel, e_bsel, e_ald, e_bld, e_oe, e_busy, e_done;
        logic sub_cyc;
        e_asel = 0; e_bsel = 0; e_ald = 0; e_bld = 0; e_oe = 0; e_busy = 0; e_done = 0;
        sub_cyc = (phase >= 2) && (phase <= n + 1);
        if (phase == 1) begin
            e_asel = 1; e_bsel = 1; e_ald = 1; e_bld = 1; e_busy = 1;
        end else if (sub_cyc) begin
            e_busy = 1;
            if (ma > mb) e_ald = 1;
            else         e_bld = 1;
        end else if (phase != 0 && phase == n + 2) begin
            e_busy = 1; e_oe = 1;
        end else if (phase != 0 && phase == n + 3) begin
            e_done = 1;
        end
        if (chk_en) begin
            chk("a_ld", bus.a_ld, e_ald);
            chk("b_ld", bus.b_ld, e_bld);
            chk("output_en", bus.output_en, e_oe);
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_done);
            chk("err", bus.err, 0);
            chk("iter_count", bus.iter_count, m_iter);
            if (phase == 1) begin
                chk("a_sel_load", bus.a_sel, 1);
                chk("b_sel_load", bus.b_sel, 1);
            end
            if (sub_cyc && e_ald) chk("a_sel_sub", bus.a_sel, 0);
            if (sub_cyc && e_bld) chk("b_sel_sub", bus.b_sel, 0);
            if (e_done) chk("result", rout, g);
        end
        if (rst) begin
            phase = 0;
            m_iter = 0;
        end else if (phase == 0) begin
            if (start_r) begin
                phase = 1;
                ma = int'(in1);
                mb = int'(in2);
                if (ma != 0 && mb != 0) begin
                    n = sub_steps(ma, mb);
                    g = gcd_of(ma, mb);
                end else begin
                    n = 1 << 20;
                    g = 0;
                end
            end
        end else if (phase == n + 3) begin
            phase = 0;
        end else begin
            if (phase == 1) begin
                m_iter = 0;
            end else if (phase <= n + 1) begin
                m_iter++;
                if (ma > mb) ma -= mb;
                else         mb -= ma;
            end
            phase++;
        end
    end

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!bus.done) begin
            if (cyc >= limit) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input int x, input int y, output int lat, output int it, output int res);
        int c;
        @(posedge clk); #1;
        in1 = 16'(x); in2 = 16'(y); start_r = 1;
        @(posedge clk); #1;
        start_r = 0;
        wait_done(3000, c);
        lat = 1 + c;
        it  = int'(bus.iter_count);
        res = int'(rout);
    endtask

    task automatic do_reset(input int cyc);
        @(posedge clk); #1;
        rst = 1;
        repeat (cyc) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic fault_run(input logic [2:0] fv);
        @(posedge clk); #1;
        in1 = 16'd9; in2 = 16'd6; start_r = 1;
        @(posedge clk); #1;
        start_r = 0;
        @(posedge clk); #1;
        force_en = 1; force_v = fv;
        #1;
        chk("fault_a_ld", bus.a_ld, 0);
        chk("fault_b_ld", bus.b_ld, 0);
        chk("fault_oe", bus.output_en, 0);
        @(posedge clk); #1;
        chk("fault_done", bus.done, 1);
        chk("fault_err", bus.err, 1);
        chk("fault_hold_a", ra, 9);
        chk("fault_hold_b", rb, 6);
        force_en = 0;
        @(posedge clk); #1;
        chk("fault_idle_done", bus.done, 0);
        chk("fault_idle_err", bus.err, 0);
        chk("fault_idle_busy", bus.busy, 0);
        do_reset(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int lat, it, res, c, x, y;
        logic seen;
        rst = 1; start_r = 1; in1 = 16'd12; in2 = 16'd8;
        force_en = 0; force_v = 3'b000; chk_en = 0;

        // Reset held two cycles with start high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_iter", bus.iter_count, 0);
        chk("rst_ld", {bus.a_ld, bus.b_ld, bus.a_sel, bus.b_sel}, 0);
        chk("rst_done_err_oe", {bus.done, bus.err, bus.output_en}, 0);
        chk_en = 1;
        rst = 0;
        @(posedge clk); #1;
        chk("first_load", {bus.a_ld, bus.b_ld}, 2'b11);
        start_r = 0;
        wait_done(100, c);
        chk("basic_latency", 1 + c, 5);
        chk("basic_iter", bus.iter_count, 2);
        chk("basic_out", rout, 4);

        run_op(7, 7, lat, it, res);
        chk("equal_latency", lat, 3);
        chk("equal_iter", it, 0);
        chk("equal_out", res, 7);

`ifndef GCD_TIMEOUT_EN
        run_op(1000, 1, lat, it, res);
        chk("long_iter", it, 999);
        chk("long_out", res, 1);
        chk("long_latency", lat, 1002);
`endif

        for (int i = 0; i < 25; i++) begin
            x = int'($urandom_range(1, RMAX));
            y = int'($urandom_range(1, RMAX));
            run_op(x, y, lat, it, res);
        end

        // start held high: re-trigger two cycles after done
        @(posedge clk); #1;
        in1 = 16'd21; in2 = 16'd14; start_r = 1;
        wait_done(100, c);
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!(bus.a_ld && bus.b_ld) && c < 10);
        chk("b2b_gap", c, 2);
        wait_done(100, c);
        chk("b2b_out", rout, 7);
        start_r = 0;

        // Reset in the middle of RUN
        @(posedge clk); #1;
        in1 = 16'd9; in2 = 16'd1; start_r = 1;
        @(posedge clk); #1;
        start_r = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrun_busy_before", bus.busy, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrun_busy", bus.busy, 0);
        chk("midrun_iter", bus.iter_count, 0);
        chk("midrun_ld", {bus.a_ld, bus.b_ld, bus.output_en}, 0);

        chk_en = 0;
        fault_run(3'b000);
        fault_run(3'b110);

        // Zero operand
        @(posedge clk); #1;
        in1 = 16'd5; in2 = 16'd0; start_r = 1;
        @(posedge clk); #1;
        start_r = 0;
        seen = 0;
`ifdef GCD_TIMEOUT_EN
        c = 0;
        while (!bus.done && c < 40) begin
            seen |= bus.output_en;
            @(posedge clk); #1;
            c++;
        end
        chk("wdog_done", bus.done, 1);
        chk("wdog_err", bus.err, 1);
        chk("wdog_iter", bus.iter_count, 10);
        chk("wdog_no_oe", seen, 0);
`else
        repeat (100) begin
            @(posedge clk); #1;
            seen |= bus.done;
        end
        chk("zero_still_busy", bus.busy, 1);
        chk("zero_no_done", seen, 0);
`endif
        do_reset(1);
        chk_en = 1;

        run_op(12, 8, lat, it, res);
        chk("final_out", res, 4);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
